// File: rtl/button_encoder.sv
// Four push-buttons: 2-flop synchronizer, per-bit debounce, priority encode to a held 2-bit code with valid/ready.
// Build option: define BUTTON_ENCODER_DEBOUNCE_EN for the debounce counters; otherwise stable follows s2 directly.
module button_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn,
    input  logic       ready,
    output logic [1:0] code,
    output logic       valid,
    output logic       overrun,
    output logic [3:0] held
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
        $error("button_encoder: DEBOUNCE_CYCLES must be >= 2");
    end

    logic [3:0] r_s1;
    logic [3:0] r_s2;
    logic [3:0] r_stable;
    logic [3:0] r_press;
    logic [3:0] w_stable_next;
    logic [1:0] r_code;
    logic       r_valid;
    logic       r_overrun;
    logic [1:0] w_enc;
    logic       w_any;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= btn;
            r_s2 <= r_s1;
        end
    end

`ifdef BUTTON_ENCODER_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt      [4];
    logic [CNT_W-1:0] w_cnt_next [4];

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_stable_next[i] = r_stable[i];
            w_cnt_next[i]    = '0;
            if (r_s2[i] != r_stable[i]) begin
                if (r_cnt[i] == CNT_MAX) begin
                    w_stable_next[i] = r_s2[i];
                end else begin
                    w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // NOTE: the counters are four small flop banks, not RAM, so they take the async reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) r_cnt[i] <= w_cnt_next[i];
        end
    end
`else
    assign w_stable_next = r_s2;
`endif

    // Press pulses are registered alongside stable, so the event register sees them one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable <= '0;
            r_press  <= '0;
        end else begin
            r_stable <= w_stable_next;
            r_press  <= w_stable_next & ~r_stable;
        end
    end

    always_comb begin
        w_any = |r_press;
        w_enc = 2'b00;
        if (r_press[3])      w_enc = 2'b11;
        else if (r_press[2]) w_enc = 2'b10;
        else if (r_press[1]) w_enc = 2'b01;
    end

    // Lower-priority simultaneous presses vanish here; only a press arriving while blocked counts as overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code    <= 2'b00;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (!r_valid) begin
            if (w_any) begin
                r_code  <= w_enc;
                r_valid <= 1'b1;
            end
        end else if (ready) begin
            r_overrun <= 1'b0;
            if (w_any) r_code  <= w_enc;
            else       r_valid <= 1'b0;
        end else if (w_any) begin
            r_overrun <= 1'b1;
        end
    end

    assign code    = r_code;
    assign valid   = r_valid;
    assign overrun = r_overrun;
    assign held    = r_stable;

endmodule

// File: tb/tb_button_encoder.sv
// Directed bench for button_encoder with DEBOUNCE_CYCLES=4; expectations follow the build option.
module tb_button_encoder;

    localparam int unsigned DB = 4;
`ifdef BUTTON_ENCODER_DEBOUNCE_EN
    localparam int LAT = DB;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn;
    logic       ready;
    logic [1:0] code;
    logic       valid;
    logic       overrun;
    logic [3:0] held;

    int n_checks = 0;
    int n_fail   = 0;

    button_encoder #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (btn),
        .ready   (ready),
        .code    (code),
        .valid   (valid),
        .overrun (overrun),
        .held    (held)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        btn   = 4'b0000;
        ready = 1'b0;
        #1;
        check("rst_code", 32'(code), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_held", 32'(held), 0);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Single press of btn[2]
        btn = 4'b0100;
        tick(1 + LAT);
        check("single_held_early", 32'(held), 4'b0000);
        tick(1);
        check("single_held", 32'(held), 4'b0100);
        check("single_valid_early", 32'(valid), 0);
        tick(1);
        check("single_valid", 32'(valid), 1);
        check("single_code", 32'(code), 2'b10);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check("single_accept", 32'(valid), 0);
        btn = 4'b0000;
        tick(3 + LAT);
        check("single_release_held", 32'(held), 0);
        check("single_release_valid", 32'(valid), 0);

`ifdef BUTTON_ENCODER_DEBOUNCE_EN
        // Bounce on btn[1]: 1,0,1,0 then hold 1
        for (int k = 0; k < 4; k++) begin
            btn = (k % 2 == 0) ? 4'b0010 : 4'b0000;
            tick(1);
            check("bounce_held", 32'(held), 0);
            check("bounce_valid", 32'(valid), 0);
        end
        btn = 4'b0010;
        tick(5);
        check("bounce_held_early", 32'(held), 0);
        tick(1);
        check("bounce_held", 32'(held), 4'b0010);
        check("bounce_valid_early", 32'(valid), 0);
        tick(1);
        check("bounce_valid", 32'(valid), 1);
        check("bounce_code", 32'(code), 2'b01);
`else
        // One-cycle glitch on btn[0] is a real press without debounce
        btn = 4'b0001;
        tick(1);
        btn = 4'b0000;
        tick(2);
        check("glitch_held", 32'(held), 4'b0001);
        check("glitch_valid_early", 32'(valid), 0);
        tick(1);
        check("glitch_valid", 32'(valid), 1);
        check("glitch_code", 32'(code), 2'b00);
`endif
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check("t2_accept", 32'(valid), 0);
        btn = 4'b0000;
        tick(3 + LAT);
        check("t2_quiet", 32'(valid), 0);

        // Simultaneous press 1011
        btn = 4'b1011;
        tick(2 + LAT);
        check("simul_held", 32'(held), 4'b1011);
        tick(1);
        check("simul_valid", 32'(valid), 1);
        check("simul_code", 32'(code), 2'b11);
        check("simul_overrun", 32'(overrun), 0);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check("simul_accept", 32'(valid), 0);
        tick(4);
        check("simul_single_event", 32'(valid), 0);
        btn = 4'b0000;
        tick(3 + LAT);

        // Overrun then back-to-back
        btn = 4'b0001;
        tick(3 + LAT);
        check("ovr_valid", 32'(valid), 1);
        check("ovr_code0", 32'(code), 2'b00);
        btn = 4'b0101;
        tick(2 + LAT);
        check("ovr_not_yet", 32'(overrun), 0);
        tick(1);
        check("ovr_code_hold", 32'(code), 2'b00);
        check("ovr_valid_hold", 32'(valid), 1);
        check("ovr_set", 32'(overrun), 1);
        btn = 4'b0111;
        tick(2 + LAT);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check("b2b_code", 32'(code), 2'b01);
        check("b2b_valid", 32'(valid), 1);
        check("b2b_overrun", 32'(overrun), 0);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check("b2b_accept", 32'(valid), 0);
        btn = 4'b0000;
        tick(3 + LAT);

        // Reset mid-count with a pending event and overrun set
        btn = 4'b0001;
        tick(3 + LAT);
        btn = 4'b1001;
        tick(3 + LAT);
        check("mid_valid", 32'(valid), 1);
        check("mid_overrun", 32'(overrun), 1);
        btn = 4'b0000;
        tick(3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_code", 32'(code), 0);
        check("mid_rst_valid", 32'(valid), 0);
        check("mid_rst_overrun", 32'(overrun), 0);
        check("mid_rst_held", 32'(held), 0);
        tick(2);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            check("post_rst_quiet", 32'(valid), 0);
        end

        // Button held through reset release counts as a new press
        rst_n = 1'b0;
        btn   = 4'b0010;
        tick(2);
        rst_n = 1'b1;
        tick(2 + LAT);
        check("thru_rst_held", 32'(held), 4'b0010);
        check("thru_rst_valid_early", 32'(valid), 0);
        tick(1);
        check("thru_rst_valid", 32'(valid), 1);
        check("thru_rst_code", 32'(code), 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_encoder.md
# button_encoder

Board-input front end that turns four bouncy, asynchronous push-buttons into a registered 2-bit binary code plus a valid/ready handshake. Each button is synchronized and debounced. Every debounced press event is priority-encoded to its bit index and held until the consumer accepts it. The `code` output uses the same bit-index-to-binary mapping as the team's 2-to-4 one-hot LED decoder, so `code` can drive that decoder directly.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000 (10 ms at 100 MHz): consecutive stable cycles required to accept a level change; legal range ≥ 2.

Ports:
- `clk`  input  1  system clock; all state on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `btn`  input  4  raw buttons, active-high, asynchronous to `clk`.
- `ready`  input  1  consumer accepts `code` in any cycle where `valid && ready`.
- `code`  output  2  index of the pressed button (btn[3]→11, btn[2]→10, btn[1]→01, btn[0]→00).
- `valid`  output  1  `code` holds an unconsumed press event.
- `overrun`  output  1  sticky; at least one press was dropped while an event was pending.
- `held`  output  4  debounced button levels.

## Operation
- Synchronizer: two flops per bit (`s1`, `s2`). Reset value 0.
- Debounce, per bit: counter of width `$clog2(DEBOUNCE_CYCLES)` and a `stable` bit.
  - If `s2 == stable`, the counter clears.
  - Else, if counter == DEBOUNCE_CYCLES−1, `stable` takes the value of `s2` and the counter clears.
  - Else, the counter increments.
  - `held = stable`.
- Press detect: `press[i] = stable_next[i] & ~stable[i]`, registered with the `stable` update. Releases generate no event.
- Priority: if several bits press in the same cycle, the highest index wins. Lower bits are discarded and do not set `overrun`.
- Event register, evaluated each cycle with `p` = any press:
  - `valid=0`, `p=1`: load `code`, `valid←1`.
  - `valid=1`, `ready=1`, `p=1`: load new `code`, `valid` stays 1, `overrun←0`.
  - `valid=1`, `ready=1`, `p=0`: `valid←0`, `overrun←0`.
  - `valid=1`, `ready=0`, `p=1`: `code` unchanged, press dropped, `overrun←1`.
  - `valid=1`, `ready=0`, `p=0`: hold.
- `code` is stable while `valid=1 && ready=0`.
- `ready` while `valid=0` has no effect.

## Timing
- Reset values (asynchronous on `rst_n`=0): `code`=00, `valid`=0, `overrun`=0, `held`=0000. All synchronizer flops, counters and `stable` bits are 0.
- Reset mid-operation drops any pending event and the `overrun` flag.
- A button held through reset release is treated as a new press and is reported after normal debounce latency.
- Press latency: edge 1 is the first edge that samples the new level into `s1`.
  - `s2` updates at edge 2.
  - `stable`/`held` updates at edge 2+DEBOUNCE_CYCLES.
  - `valid` rises at edge 3+DEBOUNCE_CYCLES.
- A glitch lasting fewer than DEBOUNCE_CYCLES cycles at `s2` clears the counter. It produces no `held` change and no event.
- Release latency to `held`=0 equals the press latency to `held`=1.
- Handshake: the transfer completes at the edge where `valid && ready`. `valid` can remain high across back-to-back events.
- No combinational path from inputs to outputs.

## Configuration
- `BUTTON_ENCODER_DEBOUNCE_EN`:
  - Defined: the debounce counters are built as described above.
  - Undefined: counters are removed and `stable` loads `s2` every cycle. Press latency becomes `held` at edge 3 and `valid` at edge 4, and `DEBOUNCE_CYCLES` is ignored. Intended for fast simulation and for glitch-free sources.

## Test plan
Benches use DEBOUNCE_CYCLES=4 unless noted.
- Reset: assert `rst_n`=0 mid-count with `valid`=1 and `overrun`=1. Outputs go to 0 immediately. After release, with `btn`=0 held, `valid` stays 0 for 20 cycles.
- Single press: `btn`=0100 from edge 1 with `ready`=0. `held`=0100 after edge 6, `valid`=1 and `code`=10 after edge 7. Raise `ready` for one cycle: `valid`=0 at the next edge.
- Bounce: on btn[1], toggle 1,0,1,0 at single-cycle intervals, then hold 1. No event during the toggling. `code`=01 at edge 3+4 counted from the final rising sample.
- Simultaneous: `btn` 0000→1011 at one edge. A single event with `code`=11 and `overrun`=0. `held`=1011.
- Overrun and back-to-back:
  - With `valid`=1 (`code`=00) and `ready`=0, press btn[2]: `code` stays 00 and `overrun`=1.
  - Next, with `ready`=1 on the same cycle as a btn[1] press: `code`=01, `valid` stays 1, `overrun`=0.
- Macro off: with `BUTTON_ENCODER_DEBOUNCE_EN` undefined, `btn`=0001 gives `valid`=1, `code`=00 at edge 4. A one-cycle glitch produces one press event.
